// File: rtl/nco_clk_div_pkg.sv
// nco_clk_div_pkg: shared state encoding, default width and increment clamp
package nco_clk_div_pkg;
  localparam int ACC_W_DEF = 24;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
  function automatic logic [31:0] clamp_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = 32'd1 << (w - 1);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/nco_phase_acc.sv
// nco_phase_acc: modulo-2^W phase accumulator with carry out and synchronous clear
module nco_phase_acc #(
  parameter int W = 24
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] acc,
  output logic         carry
);
  logic [W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign carry = en & sum[W];
  // clear wins over accumulate so a stop lands on phase 0
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum[W-1:0];
endmodule

// File: rtl/nco_clk_div.sv
// nco_clk_div: phase-accumulator fractional divider with two wrap-synchronised FSK increments
module nco_clk_div
  import nco_clk_div_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC0_RST = ACC_W'(2 ** (ACC_W - 4)),
  parameter logic [ACC_W-1:0] INC1_RST = ACC_W'(2 ** (ACC_W - 3))
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fsk_bit,
  input  logic             cfg_wr,
  input  logic             cfg_sel,
  input  logic [ACC_W-1:0] cfg_data,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_pending
);
  state_t state, state_nxt;
  logic [ACC_W-1:0] inc [2];
  logic [ACC_W-1:0] pend [2];
  logic [1:0] pend_f;
  logic [ACC_W-1:0] acc, inc_act, wr_val;
  logic sel_q, tick_q, wrap, idle, xfer, stop_end;
  assign idle = state == IDLE;
  assign inc_act = sel_q ? inc[1] : inc[0];
  assign xfer = wrap | idle;
  assign stop_end = (state == STOP) & ~enable & (wrap | (inc_act == '0));
  assign wr_val = ACC_W'(clamp_inc(32'(cfg_data), ACC_W));
  assign clk_out = acc[ACC_W-1];
  assign tick = tick_q;
  assign running = ~idle;
  assign cfg_pending = |pend_f;
  nco_phase_acc #(.W(ACC_W)) u_acc (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .clr    (idle | stop_end),
    .en     (~idle),
    .inc    (inc_act),
    .acc    (acc),
    .carry  (wrap)
  );
  // run request always wins; otherwise idle stays idle and stop ends on a wrap
  always_comb state_nxt = enable ? RUN : (idle | stop_end) ? IDLE : STOP;
  // state register
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // tone select and tick only change on period boundaries
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      sel_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (xfer) sel_q <= fsk_bit;
    end
  // shadowed increments: older value transfers, a same-edge write stays pending
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      inc[0] <= INC0_RST;
      inc[1] <= INC1_RST;
      pend[0] <= '0;
      pend[1] <= '0;
      pend_f <= '0;
    end else
      for (int i = 0; i < 2; i++) begin
        if (xfer && pend_f[i]) inc[i] <= pend[i];
        if (cfg_wr && cfg_sel == 1'(i)) begin
          pend[i] <= wr_val;
          pend_f[i] <= 1'b1;
        end else if (xfer) pend_f[i] <= 1'b0;
      end
endmodule

// File: tb/tb_nco_clk_div.sv
// tb_nco_clk_div: directed and randomized checks of nco_clk_div against a behavioural model (ACC_W=8)
module tb_nco_clk_div;
  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic fsk_bit = 1'b0;
  logic cfg_wr = 1'b0;
  logic cfg_sel = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic clk_out, tick, running, cfg_pending;
  int n_pass = 0;
  int n_tot = 0;
  int m_acc, m_mode, m_sel, m_tick;
  int m_inc[2];
  int m_pv[2];
  bit m_pf[2];

  nco_clk_div #(.ACC_W(8)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .fsk_bit    (fsk_bit),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .cfg_pending(cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // mode: 0 idle, 1 running, 2 stopping; acc is the phase as a plain integer in [0,256)
  task automatic model_reset();
    m_acc = 0;
    m_mode = 0;
    m_inc[0] = 16;
    m_inc[1] = 32;
    m_pv[0] = 0;
    m_pv[1] = 0;
    m_pf[0] = 0;
    m_pf[1] = 0;
    m_sel = 0;
    m_tick = 0;
  endtask

  task automatic model_step();
    int ia, sum, d;
    bit wrap, bound;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ia = m_inc[m_sel];
    sum = m_acc + ia;
    wrap = (m_mode != 0) && (sum >= 256);
    bound = wrap || (m_mode == 0);
    m_tick = wrap;
    for (int s = 0; s < 2; s++)
      if (bound && m_pf[s]) begin
        m_inc[s] = m_pv[s];
        m_pf[s] = 0;
      end
    if (cfg_wr) begin
      d = int'(cfg_data);
      m_pv[cfg_sel] = (d > 128) ? 128 : d;
      m_pf[cfg_sel] = 1;
    end
    if (bound) m_sel = int'(fsk_bit);
    if (m_mode == 0) begin
      m_acc = 0;
      m_mode = enable ? 1 : 0;
    end else if (enable) begin
      m_acc = sum % 256;
      m_mode = 1;
    end else if (m_mode == 2 && (wrap || ia == 0)) begin
      m_acc = 0;
      m_mode = 0;
    end else begin
      m_acc = sum % 256;
      m_mode = 2;
    end
  endtask

  task automatic compare();
    chk("clk_out", int'(clk_out), (m_acc >= 128) ? 1 : 0);
    chk("tick", int'(tick), m_tick);
    chk("running", int'(running), (m_mode != 0) ? 1 : 0);
    chk("cfg_pending", int'(cfg_pending), (m_pf[0] || m_pf[1]) ? 1 : 0);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare();
  endtask

  task automatic wr(input bit s, input int d);
    cfg_wr = 1'b1;
    cfg_sel = s;
    cfg_data = 8'(d);
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic next_tick(output int gap);
    gap = 0;
    do begin
      cyc();
      gap++;
    end while (!tick && gap < 64);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic count8(output int nt, output int nh);
    nt = 0;
    nh = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      nt += int'(tick);
      nh += int'(clk_out);
    end
  endtask

  initial begin
    int g, g2, g3, nt, nh, cnt;
    model_reset();
    cyc();
    cyc();
    chk("reset_running", int'(running), 0);
    reset_n = 1'b1;
    wr(0, 64);
    cyc();
    // integer divide by 4
    enable = 1'b1;
    next_tick(g);
    next_tick(g);
    chk("int_gap_a", g, 4);
    next_tick(g);
    chk("int_gap_b", g, 4);
    count8(nt, nh);
    chk("int_ticks8", nt, 2);
    chk("int_high8", nh, 4);
    // fractional 96/256: 3 ticks in every 8 cycles
    wr(0, 96);
    chk("frac_pending", int'(cfg_pending), 1);
    next_tick(g);
    chk("frac_pending_clr", int'(cfg_pending), 0);
    for (int w = 0; w < 3; w++) begin
      count8(nt, nh);
      chk("frac_ticks8", nt, 3);
    end
    next_tick(g);
    next_tick(g);
    next_tick(g2);
    next_tick(g3);
    chk("frac_gap_sum", g + g2 + g3, 8);
    chk("frac_gap_max", (g > 3 || g2 > 3 || g3 > 3) ? 1 : 0, 0);
    // runtime write to 128 while running at 64
    wr(0, 64);
    next_tick(g);
    next_tick(g);
    next_tick(g);
    chk("rt64_gap", g, 4);
    wr(0, 128);
    chk("rt_pending", int'(cfg_pending), 1);
    next_tick(g);
    chk("rt_pending_clr", int'(cfg_pending), 0);
    next_tick(g);
    chk("rt128_gap_a", g, 2);
    next_tick(g);
    chk("rt128_gap_b", g, 2);
    // clamp: 200 behaves as 128
    wr(0, 64);
    next_tick(g);
    next_tick(g);
    wr(0, 200);
    next_tick(g);
    count8(nt, nh);
    chk("clamp_ticks8", nt, 4);
    chk("clamp_high8", nh, 4);
    // FSK switch lands only on a period boundary
    wr(0, 32);
    wr(1, 64);
    next_tick(g);
    next_tick(g);
    next_tick(g);
    chk("fsk_gap8", g, 8);
    cyc();
    cyc();
    cyc();
    fsk_bit = 1'b1;
    next_tick(g);
    chk("fsk_switch_gap", g + 3, 8);
    next_tick(g);
    chk("fsk_gap4_a", g, 4);
    next_tick(g);
    chk("fsk_gap4_b", g, 4);
    // clean stop at inc=32
    fsk_bit = 1'b0;
    next_tick(g);
    next_tick(g);
    chk("stop_pre_gap", g, 8);
    enable = 1'b0;
    cnt = 0;
    do begin
      cyc();
      if (running) cnt++;
    end while (running && cnt < 20);
    chk("stop_run_cycles", cnt, 7);
    chk("stop_clk_low", int'(clk_out), 0);
    chk("stop_tick", int'(tick), 1);
    // resume during STOP without a gap
    enable = 1'b1;
    next_tick(g);
    next_tick(g);
    enable = 1'b0;
    cyc();
    cyc();
    cyc();
    enable = 1'b1;
    next_tick(g);
    chk("resume_gap", g + 3, 8);
    // randomized traffic with asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) fsk_bit = ~fsk_bit;
      cfg_wr = ($urandom_range(0, 15) == 0);
      cfg_sel = 1'($urandom_range(0, 1));
      cfg_data = 8'($urandom_range(0, 255));
      cyc();
      cfg_wr = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        chk("areset_clk_out", int'(clk_out), 0);
        chk("areset_tick", int'(tick), 0);
        chk("areset_running", int'(running), 0);
        chk("areset_pending", int'(cfg_pending), 0);
        model_reset();
        cyc();
        cyc();
        reset_n = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/nco_clk_div.md
# nco_clk_div

Parametrised fractional clock divider, successor to the fixed-ratio `fractional_clk_div` in the FSK transmitter clock tree. A phase accumulator produces `clk_out` at f_clk·inc/2^ACC_W, with average frequency exact to 1/2^ACC_W of f_clk. Two runtime-programmable increments are selected by `fsk_bit`, so the block serves as the FSK tone source. Increment changes and start/stop take effect only on accumulator wrap, which rules out runt pulses.

## Interface
- ACC_W, 24, accumulator width in bits; range 4–32
- INC0_RST, 2**(ACC_W-4), reset value of increment 0 (space tone)
- INC1_RST, 2**(ACC_W-3), reset value of increment 1 (mark tone)
- clk_in  in  1  system clock; all logic sits on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request
- fsk_bit  in  1  tone select: 0 → inc0, 1 → inc1
- cfg_wr  in  1  one-cycle write strobe for a new increment
- cfg_sel  in  1  which increment `cfg_wr` targets
- cfg_data  in  ACC_W  new increment value
- clk_out  out  1  divided clock, equal to acc[ACC_W-1]
- tick  out  1  one-cycle pulse per output period
- running  out  1  high in RUN and STOP
- cfg_pending  out  1  a written increment is waiting for a wrap

## Operation
- State machine states:
  - IDLE: acc held at 0.
  - RUN: acc ← acc + inc_act, modulo 2^ACC_W.
  - STOP: accumulates as in RUN and returns to IDLE on the next wrap.
- Transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→STOP when `enable`=0.
  - STOP→RUN when `enable`=1 (no break in output).
  - STOP→IDLE on the wrap cycle. Also STOP→IDLE immediately if inc_act=0.
- Wrap: the carry out of the accumulator add, in RUN or STOP.
- inc_act = inc1 if sel_q else inc0.
  - sel_q loads `fsk_bit` on every wrap and on every IDLE cycle.
  - A tone change therefore always lands on a period boundary.
- Config writes:
  - `cfg_wr` stores `cfg_data` into the pending register for `cfg_sel` and sets that register's pending flag.
  - Each pending value transfers to inc0/inc1 on the next wrap, or immediately while in IDLE.
  - A second write before transfer overwrites the first (last write wins).
  - `cfg_pending` is the OR of both pending flags.
- Clamp: a write value > 2^(ACC_W-1) is stored as 2^(ACC_W-1). The maximum output is therefore f_clk/2.
- inc=0 is legal. The accumulator freezes and `clk_out` holds its level.
- Reset values: acc=0, state=IDLE, inc0=INC0_RST, inc1=INC1_RST, sel_q=0, pending flags=0. All outputs are 0.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `enable` sampled high at edge n gives state=RUN and `running`=1 after edge n.
  - The first add happens at edge n+1.
- `clk_out` is the MSB of the acc register. Duty cycle is 50% ±1 cycle when 2^ACC_W/inc is an integer.
- `tick` is high for exactly the one cycle after the wrap edge, i.e. registered carry.
- A config write at edge n is visible in the pending register after edge n.
  - If edge n is itself a wrap, the old value is used and the new one waits for the following wrap.
- Simultaneous `cfg_wr` and transfer of the same slot: the new write is kept pending; the older value transfers.
- On the STOP→IDLE wrap edge, acc clears to 0, so `clk_out` ends low. `tick` still pulses once.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). After release the block restarts from IDLE.

## Structure
- Package `nco_clk_div_pkg` holds:
  - State enum {IDLE, RUN, STOP}.
  - Default ACC_W.
  - Clamp-limit function.
- One sub-module, `nco_phase_acc`: ACC_W adder plus register, with carry out and a synchronous clear.
- The FSM and config shadowing live in the top level.

## Test plan
All scenarios use ACC_W=8.
- **Integer divide.** inc0=64, `enable`=1 → `clk_out` has period 4 (2 high, 2 low) and `tick` fires every 4 cycles.
- **Fractional divide.** inc0=96 → exactly 3 ticks per 8 cycles, with inter-tick gaps of {3,3,2} repeating.
- **FSK switch.** inc0=32, inc1=64; toggle `fsk_bit` mid-period → the period changes from 8 to 4 only after the next `tick`, with no short pulse.
- **Runtime write.**
  - `cfg_wr` inc0=128 while running at 64 → `cfg_pending`=1 until the next wrap, then period 2.
  - Writing 200 → read back as a 128 effect (clamp).
- **Clean stop.** Drop `enable` 1 cycle after a tick at inc=32 → stays `running` for 7 more cycles, then IDLE with `clk_out`=0. Reasserting `enable` during STOP resumes without a gap.
- **Reset mid-operation.** Pulse `reset_n` low at random cycles → all outputs are 0 during reset, and after release the increments return to INC0_RST/INC1_RST.
